// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-sequencing load/store unit.
// Contents: FSM state type, RISC-V load/store funct3 codes, the funct3 codes
// used on single-byte memory beats, and the access-size decode helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        RESP
    } lsu_state_e;

    // RISC-V load/store funct3 encodings.
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Every memory beat is a single byte.
    localparam logic [2:0] BEAT_FUNCT3_LOAD  = FUNCT3_LBU;
    localparam logic [2:0] BEAT_FUNCT3_STORE = FUNCT3_SB;

    // Byte count from funct3[1:0]; the reserved size 11 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
        case (size_code)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Bus bundle between the pipeline / data memory and lsu_byte_sequencer.
// Request/response: req_valid_i, req_ready_o, req_addr_i, req_wdata_i, req_we_i,
//   req_funct3_i, resp_valid_o, resp_rdata_o, resp_err_o.
// Memory: mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o, mem_data_i.
// Modport slave is taken by the sequencer; master by whatever drives it.
interface lsu_byte_sequencer_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AWIDTH-1:0] req_addr_i;
    logic [DWIDTH-1:0] req_wdata_i;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic              resp_valid_o;
    logic [DWIDTH-1:0] resp_rdata_o;
    logic              resp_err_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [2:0]        mem_funct3_o;
    logic [DWIDTH-1:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_funct3_i, mem_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_funct3_i, mem_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );
endinterface

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Combinational load-data extension.
// Ports: asm_i (assembled little-endian bytes), funct3_i (load funct3),
//        rdata_o (sign/zero-extended result; word and unknown sizes pass through).
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);
    always_comb begin
        rdata_o = asm_i;
        case (funct3_i)
            FUNCT3_LB:  rdata_o = {{24{asm_i[7]}}, asm_i[7:0]};
            FUNCT3_LH:  rdata_o = {{16{asm_i[15]}}, asm_i[15:0]};
            FUNCT3_LBU: rdata_o = {24'b0, asm_i[7:0]};
            FUNCT3_LHU: rdata_o = {16'b0, asm_i[15:0]};
            default:    rdata_o = asm_i;
        endcase
    end
endmodule

// File: rtl/lsu_byte_sequencer.sv
// Load/store initiator that runs each request as single-byte memory beats
// (LBU beats for loads, SB beats for stores) and returns a one-cycle response.
// Ports: clk, rst (async, active-high), bus_io (lsu_byte_sequencer_if.slave) carrying
//        the pipeline request/response and the byte-wide data-memory port.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses
//           with resp_err_o instead of sequencing them.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    lsu_byte_sequencer_if.slave bus_io
);
    if (DWIDTH != 32) begin : g_dwidth_check
        $error("lsu_byte_sequencer: DWIDTH must be 32");
    end

    lsu_state_e        state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [2:0]        nbytes_q;
    logic [2:0]        cnt_q;
    logic              err_q;

    logic [2:0]  req_nbytes;
    logic        req_misalign;
    logic [31:0] ext_rdata;
    logic        in_beat;
    logic        in_resp;
    logic        unused_mem_hi;

    assign req_nbytes = size_bytes(bus_io.req_funct3_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((req_nbytes == 3'd2) && bus_io.req_addr_i[0]) ||
                          ((req_nbytes == 3'd4) && (bus_io.req_addr_i[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            nbytes_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.req_valid_i) begin
                        addr_q   <= bus_io.req_addr_i;
                        wdata_q  <= bus_io.req_wdata_i[31:0];
                        we_q     <= bus_io.req_we_i;
                        funct3_q <= bus_io.req_funct3_i;
                        nbytes_q <= req_nbytes;
                        cnt_q    <= '0;
                        asm_q    <= '0;
                        err_q    <= req_misalign;
                        state_q  <= req_misalign ? RESP : BEAT;
                    end
                end
                BEAT: begin
                    if (!we_q) begin
                        asm_q[{cnt_q[1:0], 3'b000} +: 8] <= bus_io.mem_data_i[7:0];
                    end
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    load_extend u_load_extend (
        .asm_i    (asm_q),
        .funct3_i (funct3_q),
        .rdata_o  (ext_rdata)
    );

    assign in_beat = (state_q == BEAT);
    assign in_resp = (state_q == RESP);

    // rst gates ready so it reads 0 for the whole reset window.
    assign bus_io.req_ready_o    = (state_q == IDLE) && !rst;
    assign bus_io.mem_read_en_o  = in_beat && !we_q;
    assign bus_io.mem_write_en_o = in_beat && we_q;
    assign bus_io.mem_funct3_o   = !in_beat ? 3'b000 :
                                   (we_q ? BEAT_FUNCT3_STORE : BEAT_FUNCT3_LOAD);
    assign bus_io.mem_addr_o     = in_beat ? addr_q + AWIDTH'(cnt_q) : '0;
    assign bus_io.mem_data_o     = (in_beat && we_q) ?
                                   DWIDTH'(wdata_q[{cnt_q[1:0], 3'b000} +: 8]) : '0;

    assign bus_io.resp_valid_o   = in_resp;
    assign bus_io.resp_rdata_o   = (in_resp && !we_q && !err_q) ? DWIDTH'(ext_rdata) : '0;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus_io.resp_err_o     = in_resp && err_q;
`else
    assign bus_io.resp_err_o     = 1'b0;
`endif

    assign unused_mem_hi = ^bus_io.mem_data_i[DWIDTH-1:8];
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   resp_cnt;
    logic [31:0] last_rdata;
    logic        last_err;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    beat_t beat_q[$];
    resp_t resp_q[$];

    lsu_byte_sequencer_if #(.AWIDTH(32), .DWIDTH(32)) bif ();

    lsu_byte_sequencer #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide data memory, addressed by the low 8 address bits.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bif.mem_write_en_o) mem[bif.mem_addr_o[7:0]] <= bif.mem_data_o[7:0];
    end
    assign bif.mem_data_i = {24'h0, mem[bif.mem_addr_o[7:0]]};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s got=event want=none", name);
    endtask

    // Monitor: pops expectations whenever the DUT shows a beat or a response.
    initial begin
        beat_t b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bif.mem_read_en_o || bif.mem_write_en_o) begin
                    if (beat_q.size() == 0) fail("beat_unexpected");
                    else begin
                        b = beat_q.pop_front();
                        chk("beat",
                            {bif.mem_addr_o, bif.mem_funct3_o, bif.mem_read_en_o,
                             bif.mem_write_en_o, bif.mem_data_o},
                            {b.addr, (b.we ? 3'b000 : 3'b100), !b.we, b.we,
                             (b.we ? {24'h0, b.data} : 32'h0)});
                    end
                    chk("ready_in_beat", bif.req_ready_o, 1'b0);
                end
                if (bif.resp_valid_o) begin
                    resp_cnt++;
                    last_rdata = bif.resp_rdata_o;
                    last_err   = bif.resp_err_o;
                    if (resp_q.size() == 0) fail("resp_unexpected");
                    else begin
                        r = resp_q.pop_front();
                        chk("resp", {bif.resp_rdata_o, bif.resp_err_o, 32'(cyc)},
                            {r.rdata, r.err, 32'(r.cyc)});
                    end
                    chk("ready_in_resp", bif.req_ready_o, 1'b0);
                end
            end
        end
    end

    // Issue one request (called at a negedge) and record what must come back.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int acc);
        int          n;
        int          guard;
        bit          mis;
        logic [31:0] a;
        logic [31:0] val;
        logic [31:0] res;
        resp_t       r;
        beat_t       b;
        bif.req_valid_i  = 1'b1;
        bif.req_we_i     = we;
        bif.req_funct3_i = f3;
        bif.req_addr_i   = addr;
        bif.req_wdata_i  = wd;
        guard = 0;
        while (!bif.req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc + 1;
        if (guard >= 50) begin
            fail("accept_timeout");
            bif.req_valid_i = 1'b0;
            return;
        end
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        val = 0;
        if (!mis) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                b.addr = a;
                b.we   = we;
                b.data = 8'((wd >> (8 * i)) & 32'hFF);
                beat_q.push_back(b);
                if (we) ref_mem[a[7:0]] = b.data;
                else val = val + (32'(ref_mem[a[7:0]]) << (8 * i));
            end
        end
        case (f3)
            3'b000:  res = (val >= 32'd128)   ? val + 32'hFFFF_FF00 : val;
            3'b001:  res = (val >= 32'd32768) ? val + 32'hFFFF_0000 : val;
            default: res = val;
        endcase
        r.rdata = (we || mis) ? 32'h0 : res;
        r.err   = mis;
        r.cyc   = mis ? acc : acc + n;
        resp_q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request inputs to show they are not sampled after acceptance.
        bif.req_valid_i  = 1'b0;
        bif.req_addr_i   = $urandom;
        bif.req_wdata_i  = $urandom;
        bif.req_we_i     = 1'($urandom);
        bif.req_funct3_i = 3'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((resp_q.size() != 0 || beat_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            fail("idle_timeout");
            resp_q.delete();
            beat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int          acc1;
        int          acc2;
        int          cnt0;
        logic [31:0] tmp;
        logic [7:0]  keep2;
        logic [7:0]  keep3;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] ad;
        total = 0; bad = 0; cyc = 0; resp_cnt = 0;
        rst = 1'b1;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        bif.req_valid_i = 1'b0; bif.req_we_i = 1'b0; bif.req_funct3_i = '0;
        bif.req_addr_i = '0; bif.req_wdata_i = '0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'h80; ref_mem[8'h11] = 8'h7F;
        ref_mem[8'h12] = 8'h12; ref_mem[8'h13] = 8'hF0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = 8'(i); pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
        chk("reset_outputs",
            {bif.req_ready_o, bif.mem_read_en_o, bif.mem_write_en_o, bif.resp_valid_o,
             bif.resp_err_o, bif.mem_addr_o, bif.mem_funct3_o, bif.resp_rdata_o},
            '0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bif.req_ready_o, 1'b1);

        issue(1'b0, 3'b010, 32'h0100_0010, 32'h0, acc1); wait_idle();
        chk("lw_const", last_rdata, 32'hF012_7F80);
        issue(1'b0, 3'b000, 32'h0100_0010, 32'h0, acc1); wait_idle();
        chk("lb_const", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h0100_0010, 32'h0, acc1); wait_idle();
        chk("lbu_const", last_rdata, 32'h0000_0080);
        issue(1'b1, 3'b010, 32'h0100_0020, 32'hDEAD_BEEF, acc1); wait_idle();
        chk("sw_rdata", last_rdata, 32'h0);
        issue(1'b0, 3'b001, 32'h0100_0022, 32'h0, acc1); wait_idle();
        chk("lh_const", last_rdata, 32'hFFFF_DEAD);
        issue(1'b0, 3'b101, 32'h0100_0022, 32'h0, acc1); wait_idle();
        chk("lhu_const", last_rdata, 32'h0000_DEAD);
        issue(1'b0, 3'b010, 32'h0100_0011, 32'h0, acc1); wait_idle();
        tmp = last_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_trap", {last_err, tmp}, {1'b1, 32'h0});
`else
        chk("lw_mis_low", tmp[23:0], 24'hF0_127F);
`endif
        issue(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0, acc1); wait_idle();
        issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, acc1); wait_idle();
        issue(1'b1, 3'b001, 32'hFFFF_FFFE, 32'h0000_A55A, acc1); wait_idle();

        // Back-to-back with valid effectively held.
        cnt0 = resp_cnt;
        issue(1'b0, 3'b010, 32'h0100_0010, 32'h0, acc1);
        issue(1'b0, 3'b000, 32'h0100_0010, 32'h0, acc2);
        wait_idle();
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd6);
        chk("b2b_resp_count", 32'(resp_cnt - cnt0), 32'd2);

        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom);
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            if (we && f3[2]) f3[2] = 1'b0;
            ad = ($urandom_range(0, 7) == 0) ? $urandom : (32'h0100_0000 | $urandom_range(0, 255));
            issue(we, f3, ad, $urandom, acc1);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        // Reset during the third beat of a word store.
        keep2 = ref_mem[8'h32];
        keep3 = ref_mem[8'h33];
        cnt0  = resp_cnt;
        issue(1'b1, 3'b010, 32'h0100_0030, 32'h1122_3344, acc1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_drops_enables",
            {bif.mem_write_en_o, bif.mem_read_en_o, bif.resp_valid_o, bif.req_ready_o}, 4'b0);
        ref_mem[8'h32] = keep2;
        ref_mem[8'h33] = keep3;
        beat_q.delete();
        resp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_midop_reset", bif.req_ready_o, 1'b1);
        repeat (6) @(negedge clk);
        chk("no_resp_after_abort", 32'(resp_cnt - cnt0), 32'd0);
        issue(1'b0, 3'b010, 32'h0100_0030, 32'h0, acc1); wait_idle();

        for (int i = 0; i < 256; i++) chk($sformatf("mem_%0h", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
